// File: rtl/niosbase_pio_pkg.sv
// niosbase_pio_pkg: register addresses and edge-type codes shared by the input PIO
package niosbase_pio_pkg;
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] PIO_ADDR_PENDING = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/niosbase_pio_sync.sv
// niosbase_pio_sync: per-bit flop chain bringing asynchronous inputs into the clk domain
//   clk, reset : system clock, asynchronous active-high reset (chain clears to 0)
//   d          : asynchronous inputs, WIDTH bits
//   q          : synchronised inputs, SYNC_STAGES cycles behind d
module niosbase_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/niosbase_pio_in_edge.sv
// niosbase_pio_in_edge: Avalon-MM input PIO with edge capture and masked level interrupt
//   clk, reset            : system clock, asynchronous active-high reset
//   address/read/write    : Avalon word address and strobes (0 DATA, 1 IRQMASK, 2 EDGECAP W1C, 3 PENDING)
//   writedata / readdata  : Avalon data, readdata registered (read latency 1)
//   irq                   : registered level interrupt, |(EDGECAP & IRQMASK)
//   in_port               : asynchronous external inputs, WIDTH bits
module niosbase_pio_in_edge
    import niosbase_pio_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter int          SYNC_STAGES  = 2,
    parameter int          EDGE_TYPE    = 0,
    parameter logic [31:0] IRQ_MASK_RST = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);
    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_params
        $fatal(1, "niosbase_pio_in_edge: illegal WIDTH, SYNC_STAGES or EDGE_TYPE");
    end

    logic [WIDTH-1:0] d_sync, d_prev, edge_det, w1c, edgecap, irqmask, wr_bits;
    logic [31:0]      rd_mux;
    logic             unused;

    niosbase_pio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (d_sync)
    );

    assign wr_bits = writedata[WIDTH-1:0];
    assign unused  = ^writedata;

    always_comb begin
        edge_det = EDGE_TYPE == EDGE_RISE ? d_sync & ~d_prev :
                   EDGE_TYPE == EDGE_FALL ? ~d_sync & d_prev : d_sync ^ d_prev;
        w1c      = (write && address == PIO_ADDR_EDGECAP) ? wr_bits : '0;
        rd_mux   = address == PIO_ADDR_DATA    ? 32'(d_sync)  :
                   address == PIO_ADDR_IRQMASK ? 32'(irqmask) :
                   address == PIO_ADDR_EDGECAP ? 32'(edgecap) : 32'(edgecap & irqmask);
    end

    // Set is OR-ed after the clear so a new edge wins over a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_prev   <= '0;
            edgecap  <= '0;
            irqmask  <= IRQ_MASK_RST[WIDTH-1:0];
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            d_prev   <= d_sync;
            edgecap  <= (edgecap & ~w1c) | edge_det;
            irqmask  <= (write && address == PIO_ADDR_IRQMASK) ? wr_bits : irqmask;
            irq      <= |(edgecap & irqmask);
            readdata <= read ? rd_mux : readdata;
        end
    end
endmodule

// File: tb/tb_niosbase_pio_in_edge.sv
// tb_niosbase_pio_in_edge: directed bench for two PIO configurations against a history-based model
module tb_niosbase_pio_in_edge;
    localparam int          SYN  [2] = '{2, 3};
    localparam int          ET   [2] = '{0, 2};
    localparam logic [31:0] WM   [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    localparam logic [31:0] MRST [2] = '{32'h0, 32'h5A};

    logic        clk = 0, reset = 1;
    logic [1:0]  addr [2];
    logic        rd_s [2], wr_s [2];
    logic [31:0] wd [2], rdata [2];
    logic        irq_o [2];
    logic [31:0] in0;
    logic [7:0]  in1;
    int          errors = 0, checks = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    niosbase_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MASK_RST(32'h0)) dut0 (
        .clk(clk), .reset(reset), .address(addr[0]), .read(rd_s[0]), .write(wr_s[0]),
        .writedata(wd[0]), .readdata(rdata[0]), .irq(irq_o[0]), .in_port(in0));
    niosbase_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MASK_RST(32'h5A)) dut1 (
        .clk(clk), .reset(reset), .address(addr[1]), .read(rd_s[1]), .write(wr_s[1]),
        .writedata(wd[1]), .readdata(rdata[1]), .irq(irq_o[1]), .in_port(in1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: hist[k][j] is the input sampled j+1 clock edges ago; the synchroniser output
    // seen at an edge is the sample SYN edges old, and its predecessor is SYN+1 edges old.
    logic [31:0] hist [2][5];
    logic [31:0] m_ec [2], m_mask [2], m_rd [2];
    logic        m_irq [2];
    logic [31:0] cur, prv, ed, clr, pin;

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int j = 0; j < 5; j++) hist[k][j] = '0;
                m_ec[k] = '0; m_mask[k] = MRST[k] & WM[k]; m_rd[k] = '0; m_irq[k] = 1'b0;
            end else begin
                cur = hist[k][SYN[k]-1];
                prv = hist[k][SYN[k]];
                ed  = ET[k] == 0 ? cur & ~prv : ET[k] == 1 ? ~cur & prv : cur ^ prv;
                if (rd_s[k])
                    m_rd[k] = addr[k] == 0 ? cur : addr[k] == 1 ? m_mask[k] :
                              addr[k] == 2 ? m_ec[k] : m_ec[k] & m_mask[k];
                m_irq[k] = (m_ec[k] & m_mask[k]) != 0;
                clr = (wr_s[k] && addr[k] == 2) ? wd[k] : 32'h0;
                m_ec[k] = ((m_ec[k] & ~clr) | ed) & WM[k];
                if (wr_s[k] && addr[k] == 1) m_mask[k] = wd[k] & WM[k];
                for (int j = 4; j > 0; j--) hist[k][j] = hist[k][j-1];
                pin = k == 0 ? in0 : {24'h0, in1};
                hist[k][0] = pin & WM[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("readdata%0d", k), rdata[k], m_rd[k]);
            chk($sformatf("irq%0d", k), {31'h0, irq_o[k]}, {31'h0, m_irq[k]});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic rd(input int k, input logic [1:0] a, output logic [31:0] val);
        addr[k] = a; rd_s[k] = 1;
        @(posedge clk); @(negedge clk);
        rd_s[k] = 0; val = rdata[k];
    endtask

    task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
        addr[k] = a; wd[k] = d; wr_s[k] = 1;
        @(posedge clk); @(negedge clk);
        wr_s[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin addr[k] = 0; rd_s[k] = 0; wr_s[k] = 0; wd[k] = 0; end
        in0 = 0; in1 = 0;
        idle(2);
        reset = 0;
        idle(1);
        // reset values
        rd(0, 1, v); chk("mask0_rst", v, 32'h0);
        rd(1, 1, v); chk("mask1_rst", v, 32'h5A);
        rd(0, 2, v); chk("ecap0_rst", v, 32'h0);
        // data path latency: visible in readdata on the 3rd edge after the change
        in0 = 32'hA5A5_00FF; addr[0] = 0; rd_s[0] = 1;
        idle(2); chk("data_early", rdata[0], 32'h0);
        idle(1); chk("data_lat", rdata[0], 32'hA5A5_00FF);
        rd_s[0] = 0;
        idle(2); wr(0, 2, 32'hFFFF_FFFF);
        in0 = 0; idle(4); wr(0, 2, 32'hFFFF_FFFF);
        rd(0, 2, v); chk("fall_ignored", v, 32'h0);
        // rising edge and W1C
        wr(0, 1, 32'h1);
        in0 = 32'h1;
        idle(3); chk("irq_lag", {31'h0, irq_o[0]}, 32'h0);
        idle(1); chk("irq_set", {31'h0, irq_o[0]}, 32'h1);
        rd(0, 2, v); chk("ecap_bit0", v, 32'h1);
        rd(0, 2, v); chk("read_no_clear", v, 32'h1);
        wr(0, 2, 32'h1); chk("irq_w1c_lag", {31'h0, irq_o[0]}, 32'h1);
        idle(1); chk("irq_cleared", {31'h0, irq_o[0]}, 32'h0);
        // set/clear collision on bit 3
        wr(0, 1, 32'h8);
        in0 = 32'h9; idle(4);
        in0 = 32'h1; idle(4);
        in0 = 32'h9; idle(2);
        wr(0, 2, 32'h8); chk("collide_irq", {31'h0, irq_o[0]}, 32'h1);
        rd(0, 2, v); chk("collide_ecap", v, 32'h8);
        chk("collide_irq2", {31'h0, irq_o[0]}, 32'h1);
        // mask gating
        wr(0, 2, 32'hFFFF_FFFF);
        wr(0, 1, 32'h10);
        in0 = 32'h39; idle(5);
        rd(0, 3, v); chk("pending", v, 32'h10);
        chk("mask_irq", {31'h0, irq_o[0]}, 32'h1);
        wr(0, 1, 32'h0); chk("mask_lag", {31'h0, irq_o[0]}, 32'h1);
        idle(1); chk("masked_off", {31'h0, irq_o[0]}, 32'h0);
        rd(0, 2, v); chk("ecap_kept", v, 32'h30);
        wr(0, 3, 32'hFFFF); wr(0, 0, 32'hFFFF);
        rd(0, 3, v); chk("ro_writes", v, 32'h0);
        // read+write same cycle returns pre-write value
        addr[0] = 1; wd[0] = 32'h55; rd_s[0] = 1; wr_s[0] = 1;
        @(posedge clk); @(negedge clk);
        rd_s[0] = 0; wr_s[0] = 0;
        chk("rw_old", rdata[0], 32'h0);
        rd(0, 1, v); chk("rw_new", v, 32'h55);
        // WIDTH=8, any-edge instance
        wr(1, 1, 32'hFFFF_FFFF);
        rd(1, 1, v); chk("w8_mask", v, 32'h0000_00FF);
        in1 = 8'h80; idle(5);
        rd(1, 2, v); chk("w8_rise", v, 32'h80);
        chk("w8_irq", {31'h0, irq_o[1]}, 32'h1);
        wr(1, 2, 32'h80); idle(1);
        rd(1, 2, v); chk("w8_clr", v, 32'h0);
        in1 = 8'h00; idle(5);
        rd(1, 2, v); chk("w8_fall", v, 32'h80);
        rd(1, 0, v); chk("w8_data", v, 32'h0);
        // asynchronous reset mid-cycle, inputs held high through it
        @(posedge clk); #2 reset = 1; #1;
        chk("rst_rd0", rdata[0], 32'h0); chk("rst_rd1", rdata[1], 32'h0);
        chk("rst_irq0", {31'h0, irq_o[0]}, 32'h0); chk("rst_irq1", {31'h0, irq_o[1]}, 32'h0);
        @(negedge clk); idle(1);
        reset = 0;
        idle(5);
        rd(0, 2, v); chk("rst_rise", v, 32'h39);
        rd(0, 1, v); chk("rst_mask0", v, 32'h0);
        rd(1, 1, v); chk("rst_mask1", v, 32'h5A);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
